pad_share_arbiter: RTL and testbench

- Shares the chip's east, west and north IO pad banks among NUM_MACROS user macros, one owner at a time.
- Arbitrates macro requests round-robin and enforces a maximum tenure when others are waiting.
- Inserts an all-pads-tristated guard interval between owners to prevent drive contention.
- Sits between the macro array and the pad ring; a fixed-owner configuration mode supports bring-up and debug.

---
 rtl/pad_share_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_pad_share_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_share_arbiter.sv
// Time-shares the east/west/north pad banks among NUM_MACROS macros: round-robin
// arbitration with tenure limit, a fixed-owner debug mode, and a tristated guard gap.
module pad_share_arbiter #(
   parameter int NUM_MACROS = 4,
   parameter int EW_W       = 14,
   parameter int N_W        = 10,
   parameter int GUARD      = 2,
   parameter int MAX_TENURE = 64,
   parameter int IDXW       = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_MACROS-1:0]      req,
   input  logic                       cfg_fixed_en,
   input  logic [IDXW-1:0]            cfg_fixed_sel,
   input  logic [NUM_MACROS*EW_W-1:0] macro_east_o,
   input  logic [NUM_MACROS*EW_W-1:0] macro_east_oe,
   input  logic [NUM_MACROS*EW_W-1:0] macro_west_o,
   input  logic [NUM_MACROS*EW_W-1:0] macro_west_oe,
   input  logic [NUM_MACROS*N_W-1:0]  macro_north_o,
   input  logic [NUM_MACROS*N_W-1:0]  macro_north_oe,
   output logic [EW_W-1:0]            pad_east_o,
   output logic [EW_W-1:0]            pad_east_oe,
   output logic [EW_W-1:0]            pad_west_o,
   output logic [EW_W-1:0]            pad_west_oe,
   output logic [N_W-1:0]             pad_north_o,
   output logic [N_W-1:0]             pad_north_oe,
   output logic [NUM_MACROS-1:0]      grant,
   output logic                       grant_valid,
   output logic [IDXW-1:0]            owner_idx
);

   localparam int TW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_MACROS - 1);
   localparam logic [TW-1:0]   TEN_LIM  = TW'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);
   localparam logic [3:0]      GUARD_M1 = 4'(GUARD - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_OWN} state_t;

   state_t                state_q, state_d;
   logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDXW-1:0]       owner_idx_q, owner_idx_d;
   logic [3:0]            guard_q, guard_d;
   logic [TW-1:0]         tenure_q, tenure_d;
   logic [NUM_MACROS-1:0] grant_q, grant_d;
   logic                  grant_valid_q, grant_valid_d;
   logic [EW_W-1:0]       east_o_q, east_o_d, east_oe_q, east_oe_d;
   logic [EW_W-1:0]       west_o_q, west_o_d, west_oe_q, west_oe_d;
   logic [N_W-1:0]        north_o_q, north_o_d, north_oe_q, north_oe_d;

   logic [EW_W-1:0]       own_east_o, own_east_oe, own_west_o, own_west_oe;
   logic [N_W-1:0]        own_north_o, own_north_oe;
   logic                  arb_found;
   logic [IDXW-1:0]       arb_idx;
   int                    arb_k;
   logic                  sel_ok, own_req, others_req, release_own;

   // Owner's pad slices, muxed from the flattened macro buses.
   always_comb begin
      own_east_o   = '0;
      own_east_oe  = '0;
      own_west_o   = '0;
      own_west_oe  = '0;
      own_north_o  = '0;
      own_north_oe = '0;
      for (int k = 0; k < NUM_MACROS; k++) begin
         if (owner_idx_q == k[IDXW-1:0]) begin
            own_east_o   = macro_east_o[k*EW_W +: EW_W];
            own_east_oe  = macro_east_oe[k*EW_W +: EW_W];
            own_west_o   = macro_west_o[k*EW_W +: EW_W];
            own_west_oe  = macro_west_oe[k*EW_W +: EW_W];
            own_north_o  = macro_north_o[k*N_W +: N_W];
            own_north_oe = macro_north_oe[k*N_W +: N_W];
         end
      end
   end

   // Round-robin search starts just after the last granted index.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_k     = 0;
      for (int i = 1; i <= NUM_MACROS; i++) begin
         arb_k = (int'(rr_ptr_q) + i) % NUM_MACROS;
         if (!arb_found && req[arb_k]) begin
            arb_found = 1'b1;
            arb_idx   = arb_k[IDXW-1:0];
         end
      end
   end

   always_comb begin
      sel_ok      = (int'(cfg_fixed_sel) < NUM_MACROS);
      own_req     = |(req & grant_q);
      others_req  = |(req & ~grant_q);
      release_own = cfg_fixed_en ? (cfg_fixed_sel != owner_idx_q)
                                 : (!own_req || ((MAX_TENURE != 0) && (tenure_q >= TEN_LIM) && others_req));
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      owner_idx_d   = owner_idx_q;
      guard_d       = guard_q;
      tenure_d      = tenure_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      east_o_d      = east_o_q;
      east_oe_d     = east_oe_q;
      west_o_d      = west_o_q;
      west_oe_d     = west_oe_q;
      north_o_d     = north_o_q;
      north_oe_d    = north_oe_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_fixed_en) begin
               if (sel_ok) begin
                  owner_idx_d = cfg_fixed_sel;
                  guard_d     = GUARD_M1;
                  state_d     = ST_TURN;
               end
            end else if (arb_found) begin
               owner_idx_d = arb_idx;
               guard_d     = GUARD_M1;
               state_d     = ST_TURN;
            end
         end
         ST_TURN: begin
            if (guard_q == '0) begin
               state_d              = ST_OWN;
               grant_d              = '0;
               grant_d[owner_idx_q] = 1'b1;
               grant_valid_d        = 1'b1;
               rr_ptr_d             = owner_idx_q;
               tenure_d             = '0;
            end else begin
               guard_d = guard_q - 4'd1;
            end
         end
         ST_OWN: begin
            if (release_own) begin
               // Drop every oe on the release edge; data lines keep their last value.
               state_d       = ST_IDLE;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               east_oe_d     = '0;
               west_oe_d     = '0;
               north_oe_d    = '0;
            end else begin
               east_o_d   = own_east_o;
               east_oe_d  = own_east_oe;
               west_o_d   = own_west_o;
               west_oe_d  = own_west_oe;
               north_o_d  = own_north_o;
               north_oe_d = own_north_oe;
               if (tenure_q != '1) tenure_d = tenure_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= LAST_IDX;
         owner_idx_q   <= '0;
         guard_q       <= '0;
         tenure_q      <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         east_o_q      <= '0;
         east_oe_q     <= '0;
         west_o_q      <= '0;
         west_oe_q     <= '0;
         north_o_q     <= '0;
         north_oe_q    <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         owner_idx_q   <= owner_idx_d;
         guard_q       <= guard_d;
         tenure_q      <= tenure_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         east_o_q      <= east_o_d;
         east_oe_q     <= east_oe_d;
         west_o_q      <= west_o_d;
         west_oe_q     <= west_oe_d;
         north_o_q     <= north_o_d;
         north_oe_q    <= north_oe_d;
      end
   end

   assign grant        = grant_q;
   assign grant_valid  = grant_valid_q;
   assign owner_idx    = owner_idx_q;
   assign pad_east_o   = east_o_q;
   assign pad_east_oe  = east_oe_q;
   assign pad_west_o   = west_o_q;
   assign pad_west_oe  = west_oe_q;
   assign pad_north_o  = north_o_q;
   assign pad_north_oe = north_oe_q;

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Bench for pad_share_arbiter: ownership timeline predicted from round-robin, tenure
// and guard rules with plain arithmetic; random pad data checked one cycle later.
module tb_pad_share_arbiter;

   localparam int NM    = 4;
   localparam int EW    = 14;
   localparam int NW    = 10;
   localparam int GUARD = 2;
   localparam int MAXT  = 8;
   localparam int IDXW  = 2;
   localparam int PER   = MAXT + GUARD + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NM-1:0]     req;
   logic              cfg_fixed_en;
   logic [IDXW-1:0]   cfg_fixed_sel;
   logic [NM*EW-1:0]  macro_east_o, macro_east_oe, macro_west_o, macro_west_oe;
   logic [NM*NW-1:0]  macro_north_o, macro_north_oe;
   logic [EW-1:0]     pad_east_o, pad_east_oe, pad_west_o, pad_west_oe;
   logic [NW-1:0]     pad_north_o, pad_north_oe;
   logic [NM-1:0]     grant;
   logic              grant_valid;
   logic [IDXW-1:0]   owner_idx;

   int n_tests = 0;
   int n_fail  = 0;
   int model_rr;

   pad_share_arbiter #(
      .NUM_MACROS(NM), .EW_W(EW), .N_W(NW), .GUARD(GUARD), .MAX_TENURE(MAXT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .cfg_fixed_en(cfg_fixed_en), .cfg_fixed_sel(cfg_fixed_sel),
      .macro_east_o(macro_east_o), .macro_east_oe(macro_east_oe),
      .macro_west_o(macro_west_o), .macro_west_oe(macro_west_oe),
      .macro_north_o(macro_north_o), .macro_north_oe(macro_north_oe),
      .pad_east_o(pad_east_o), .pad_east_oe(pad_east_oe),
      .pad_west_o(pad_west_o), .pad_west_oe(pad_west_oe),
      .pad_north_o(pad_north_o), .pad_north_oe(pad_north_oe),
      .grant(grant), .grant_valid(grant_valid), .owner_idx(owner_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      logic [63:0] t;
      t = {$urandom(), $urandom()}; macro_east_o   = t[NM*EW-1:0];
      t = {$urandom(), $urandom()}; macro_east_oe  = t[NM*EW-1:0];
      t = {$urandom(), $urandom()}; macro_west_o   = t[NM*EW-1:0];
      t = {$urandom(), $urandom()}; macro_west_oe  = t[NM*EW-1:0];
      t = {$urandom(), $urandom()}; macro_north_o  = t[NM*NW-1:0];
      t = {$urandom(), $urandom()}; macro_north_oe = t[NM*NW-1:0];
   endtask

   // Owner after edge n of a run that starts from IDLE with mask held and pointer p; -1 = none.
   function automatic int exp_owner(input logic [NM-1:0] mask, input int p, input int n);
      int order[$];
      int idx, m;
      for (int i = 1; i <= NM; i++) begin
         idx = (p + i) % NM;
         if (mask[idx]) order.push_back(idx);
      end
      if (n <= GUARD || order.size() == 0) return -1;
      m = n - GUARD - 1;
      if (order.size() == 1) return order[0];
      if ((m % PER) >= MAXT) return -1;
      return order[(m / PER) % order.size()];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; req = '0; cfg_fixed_en = 1'b0; cfg_fixed_sel = '0;
      drive_rand();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (grant !== '0 || grant_valid !== 1'b0 || owner_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: grant=%b valid=%b owner=%0d, required 0/0/0", grant, grant_valid, owner_idx);
      end
      n_tests++;
      if ({pad_east_o, pad_east_oe, pad_west_o, pad_west_oe, pad_north_o, pad_north_oe} !== '0) begin
         n_fail++;
         $display("FAIL reset_pads: east_o=%h east_oe=%h north_oe=%h, required all 0", pad_east_o, pad_east_oe, pad_north_oe);
      end
      @(negedge clk) rst_n = 1'b1;
      model_rr = NM - 1;
      repeat (2) tick();
      n_tests++;
      if (grant !== '0 || grant_valid !== 1'b0 || pad_east_oe !== '0) begin
         n_fail++;
         $display("FAIL idle_after_reset: grant=%b valid=%b east_oe=%h, required 0", grant, grant_valid, pad_east_oe);
      end
   endtask

   // Hold mask for n_drop edges, checking grants and pads against the model, then drop req.
   task automatic test_arb_round(input logic [NM-1:0] mask, input int n_drop);
      int p, o, o_prev;
      logic [NM-1:0] eg;
      logic [EW-1:0] held;
      bit fwd;
      p = model_rr; o_prev = -1; fwd = 0; held = '0;
      req = mask;
      for (int n = 1; n <= n_drop; n++) begin
         tick();
         o = exp_owner(mask, p, n);
         eg = '0;
         if (o >= 0) eg[o] = 1'b1;
         n_tests++;
         if (grant !== eg || grant_valid !== (o >= 0) || (o >= 0 && owner_idx !== o[IDXW-1:0])) begin
            n_fail++;
            $display("FAIL arb_grant mask=%b n=%0d: grant=%b valid=%b owner=%0d, required grant=%b", mask, n, grant, grant_valid, owner_idx, eg);
         end
         n_tests++;
         if (o >= 0 && o == o_prev) begin
            held = macro_east_o[o*EW +: EW];
            fwd  = 1;
            if (pad_east_o !== macro_east_o[o*EW +: EW] || pad_east_oe !== macro_east_oe[o*EW +: EW] ||
                pad_west_o !== macro_west_o[o*EW +: EW] || pad_west_oe !== macro_west_oe[o*EW +: EW] ||
                pad_north_o !== macro_north_o[o*NW +: NW] || pad_north_oe !== macro_north_oe[o*NW +: NW]) begin
               n_fail++;
               $display("FAIL arb_pads n=%0d owner=%0d: east_o=%h east_oe=%h, required %h %h", n, o, pad_east_o, pad_east_oe,
                        macro_east_o[o*EW +: EW], macro_east_oe[o*EW +: EW]);
            end
         end else begin
            if (pad_east_oe !== '0 || pad_west_oe !== '0 || pad_north_oe !== '0) begin
               n_fail++;
               $display("FAIL arb_guard n=%0d: east_oe=%h west_oe=%h north_oe=%h, required 0", n, pad_east_oe, pad_west_oe, pad_north_oe);
            end
         end
         o_prev = o;
         drive_rand();
      end
      model_rr = o_prev;
      req = '0;
      tick();
      n_tests++;
      if (grant !== '0 || grant_valid !== 1'b0 || pad_east_oe !== '0 || pad_west_oe !== '0 || pad_north_oe !== '0) begin
         n_fail++;
         $display("FAIL arb_release: grant=%b valid=%b east_oe=%h, required 0", grant, grant_valid, pad_east_oe);
      end
      if (fwd) begin
         n_tests++;
         if (pad_east_o !== held) begin
            n_fail++;
            $display("FAIL arb_hold: east_o=%h, required %h", pad_east_o, held);
         end
      end
      repeat (2) tick();
      n_tests++;
      if (grant !== '0 || grant_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_idle: grant=%b valid=%b, required 0", grant, grant_valid);
      end
   endtask

   task automatic test_round_robin();
      test_arb_round(4'b1011, GUARD + 1 + 3*PER + MAXT - 1);
   endtask

   task automatic test_first_grant();
      logic [NM-1:0] exp_g;
      req = 4'b0100;
      macro_east_o = '0; macro_east_oe = '0;
      macro_east_o[2*EW +: EW]  = 14'h0004;
      macro_east_oe[2*EW +: EW] = 14'h3FFF;
      for (int n = 1; n <= GUARD + 1; n++) begin
         tick();
         exp_g = (n == GUARD + 1) ? 4'b0100 : 4'b0000;
         n_tests++;
         if (grant !== exp_g || grant_valid !== (n == GUARD + 1)) begin
            n_fail++;
            $display("FAIL first_grant n=%0d: grant=%b valid=%b, required %b", n, grant, grant_valid, exp_g);
         end
      end
      tick();
      n_tests++;
      if (pad_east_o !== 14'h0004 || pad_east_oe !== 14'h3FFF) begin
         n_fail++;
         $display("FAIL first_pads: east_o=%h east_oe=%h, required 0004 3fff", pad_east_o, pad_east_oe);
      end
      req = '0;
      tick();
      n_tests++;
      if (grant !== '0 || pad_east_oe !== '0) begin
         n_fail++;
         $display("FAIL first_release: grant=%b east_oe=%h, required 0", grant, pad_east_oe);
      end
      model_rr = 2;
      tick();
   endtask

   task automatic test_no_preempt();
      test_arb_round(4'b0001, 105);
   endtask

   task automatic test_random();
      logic [NM-1:0] mask;
      int k, r;
      for (int i = 0; i < 6; i++) begin
         mask = NM'($urandom_range(1, 15));
         k = $urandom_range(0, 3);
         r = $urandom_range(0, MAXT - 1);
         test_arb_round(mask, GUARD + 1 + k*PER + r);
      end
   endtask

   task automatic test_fixed();
      logic [NM-1:0] exp_g;
      cfg_fixed_en = 1'b1; cfg_fixed_sel = 2'd3; req = '0;
      drive_rand();
      for (int n = 1; n <= GUARD + 1; n++) begin
         tick();
         exp_g = (n == GUARD + 1) ? 4'b1000 : 4'b0000;
         n_tests++;
         if (grant !== exp_g) begin
            n_fail++;
            $display("FAIL fixed_grant n=%0d: grant=%b, required %b", n, grant, exp_g);
         end
         drive_rand();
      end
      for (int n = 0; n < 2*MAXT + 4; n++) begin
         req = NM'($urandom_range(0, 15));
         tick();
         n_tests++;
         if (grant !== 4'b1000 || grant_valid !== 1'b1 || owner_idx !== 2'd3 ||
             pad_east_oe !== macro_east_oe[3*EW +: EW] || pad_north_o !== macro_north_o[3*NW +: NW]) begin
            n_fail++;
            $display("FAIL fixed_hold n=%0d: grant=%b owner=%0d east_oe=%h, required 1000 3 %h", n, grant, owner_idx,
                     pad_east_oe, macro_east_oe[3*EW +: EW]);
         end
         drive_rand();
      end
      cfg_fixed_sel = 2'd1;
      for (int n = 1; n <= GUARD + 2; n++) begin
         tick();
         exp_g = (n == GUARD + 2) ? 4'b0010 : 4'b0000;
         n_tests++;
         if (grant !== exp_g || (n <= GUARD + 1 && pad_east_oe !== '0)) begin
            n_fail++;
            $display("FAIL fixed_switch n=%0d: grant=%b east_oe=%h, required %b", n, grant, pad_east_oe, exp_g);
         end
      end
      req = '0;
      cfg_fixed_en = 1'b0;
      tick();
      n_tests++;
      if (grant !== '0 || grant_valid !== 1'b0 || pad_west_oe !== '0) begin
         n_fail++;
         $display("FAIL fixed_exit: grant=%b valid=%b west_oe=%h, required 0", grant, grant_valid, pad_west_oe);
      end
      model_rr = 1;
      tick();
   endtask

   task automatic test_reset_mid_own();
      logic [NM-1:0] exp_g;
      req = 4'b0100;
      macro_east_oe = '0;
      macro_east_oe[2*EW +: EW] = 14'h3FFF;
      repeat (GUARD + 2) tick();
      n_tests++;
      if (pad_east_oe !== 14'h3FFF || grant !== 4'b0100) begin
         n_fail++;
         $display("FAIL mid_own_setup: grant=%b east_oe=%h, required 0100 3fff", grant, pad_east_oe);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (pad_east_oe !== '0 || grant !== '0 || grant_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: grant=%b valid=%b east_oe=%h, required 0", grant, grant_valid, pad_east_oe);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1111;
      for (int n = 1; n <= GUARD + 1; n++) begin
         tick();
         exp_g = (n == GUARD + 1) ? 4'b0001 : 4'b0000;
         n_tests++;
         if (grant !== exp_g) begin
            n_fail++;
            $display("FAIL post_reset_rr n=%0d: grant=%b, required %b", n, grant, exp_g);
         end
      end
      req = '0;
      tick();
      n_tests++;
      if (grant !== '0) begin
         n_fail++;
         $display("FAIL post_reset_release: grant=%b, required 0", grant);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_first_grant();
      test_no_preempt();
      test_random();
      test_fixed();
      test_random();
      test_reset_mid_own();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
